cpu_control: RTL and testbench
==============================

CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter START_PC, default 8'd100, is the first instruction address after reset.
REQ-003 Port CLK, input, 1, is the rising-edge clock.
REQ-004 Port RST_N, input, 1, is the asynchronous active-low reset.
REQ-005 Port MAR, output, 16, is the instruction fetch address to memory; bits [15:8] are always 0.
REQ-006 Port OUT_MEMORY, input, 16, is the instruction word read at MAR; the read is combinational.
REQ-007 Port ADDRESS, output, 8, is the operand/store address to memory.
REQ-008 Port OUT_ADDRESS_MEMORY, input, 16, is the operand word read at ADDRESS; the read is combinational.
REQ-009 Port IN_ADDRESS_MEMORY, output, 16, is the store data written to memory at ADDRESS.
REQ-010 Port MEM_WE, output, 1, is the store strobe: a one-cycle pulse, valid with ADDRESS and IN_ADDRESS_MEMORY.
REQ-011 Port AR_OUT, output, 16, shows the AR register.
REQ-012 Port RESULT_OUT, output, 16, shows the RESULT register.
REQ-013 Port PC_OUT, output, 8, shows the program counter.
REQ-014 Port HALT, output, 1, is sticky and means the sequencer has stopped.
REQ-015 Port ERR, output, 1, is sticky and means an illegal instruction or a divide by zero occurred.

Function
REQ-016 Instruction format:
- [15:12] opcode; only 4'b0001 is legal.
- [11:8] sub-op.
- [7:0] memory address.
REQ-017 The FSM SHALL have the states FETCH, DECODE, EXEC and HALTED, and take 3 cycles per instruction.
REQ-018 FETCH, one cycle, with MAR = {8'h00, PC}: on the exiting edge, IR <= OUT_MEMORY and ADDRESS <= OUT_MEMORY[7:0].
REQ-019 In DECODE, one cycle, an opcode other than 4'b0001 or an undefined sub-op SHALL set ERR and go to HALTED; otherwise, on the exiting edge, OPR <= OUT_ADDRESS_MEMORY.
REQ-020 In EXEC, one cycle, the sub-op SHALL act as follows:
- 0000: AR <= OPR.
- 0001: RESULT <= AR+OPR.
- 0010: RESULT <= AR-OPR.
- 0011: RESULT <= AR*OPR.
- 0100: RESULT <= AR/OPR.
- 1111: IN_ADDRESS_MEMORY <= RESULT and MEM_WE = 1 for this cycle only.
REQ-021 At the EXEC exit edge, PC <= PC+1 and the state returns to FETCH.
REQ-022 Add and subtract SHALL wrap modulo 2^16; multiply SHALL keep the low 16 bits; divide SHALL be unsigned with quotient truncated.
REQ-023 Divide by zero SHALL set RESULT to 16'hFFFF and set ERR; execution continues.
REQ-024 If EXEC completes with PC = 8'hFF, the FSM SHALL go to HALTED; PC SHALL never wrap to 0.
REQ-025 HALTED is terminal until reset:
- all registers hold;
- MEM_WE = 0;
- MAR and ADDRESS hold their values.
REQ-026 IN_ADDRESS_MEMORY and ADDRESS SHALL change only on FETCH and EXEC edges, never during the MEM_WE cycle.
REQ-027 Store SHALL write RESULT, not AR.

Reset
REQ-028 While RST_N = 0, the outputs SHALL immediately be:
- PC = START_PC;
- MAR = {8'h00, START_PC};
- ADDRESS = 0, IN_ADDRESS_MEMORY = 0;
- AR = 0, RESULT = 0, IR = 0, OPR = 0;
- MEM_WE = 0, HALT = 0, ERR = 0;
- state = FETCH.
REQ-029 Reset asserted in any state, including mid-EXEC of a store, SHALL cancel the in-flight operation with no write pulse.
REQ-030 After RST_N rises, the first fetch of START_PC SHALL complete on the first rising edge.

Structure
REQ-031 A shared package cpu_pkg SHALL hold:
- the opcode constant OP_ALU = 4'b0001;
- the sub-op constants LOAD, ADD, SUB, MUL, DIV, STORE;
- the FSM state encoding;
- the default START_PC.
REQ-032 The combinational ALU SHALL be a sub-module, cpu_alu, with inputs AR, OPR and sub-op and outputs RESULT and DIV0; the FSM lives in cpu_control.

Verification
REQ-033 Add and store:
- Stimulus: mem[1]=1, mem[2]=2, mem[100]=16'h1001, mem[101]=16'h1102, mem[102]=16'h1F07.
- Required response: RESULT_OUT=3; MEM_WE pulses once with ADDRESS=7 and IN_ADDRESS_MEMORY=3; mem[7]=3.
REQ-034 Subtract and multiply:
- Stimulus: AR=128, then sub mem[4]=64; then AR=12, mul mem[5]=12.
- Required response: RESULT=64, then RESULT=144.
REQ-035 Divide:
- Stimulus: AR=3072, div by 2.
- Required response: RESULT=1536, ERR=0.
- Stimulus: div by 0.
- Required response: RESULT=16'hFFFF, ERR=1, PC still advances.
REQ-036 Halt and timing:
- Stimulus: mem[103]=16'h0000.
- Required response: HALT=1 and ERR=1 after DECODE; PC_OUT=103 frozen; no further MEM_WE.
- Timing: exactly 3 cycles between successive MAR changes.
REQ-037 Reset mid-operation:
- Stimulus: RST_N=0 during the store EXEC cycle.
- Required response: MEM_WE=0 immediately; the target word is unchanged; PC=100 and MAR=100 after release.
REQ-038 End of memory:
- Stimulus: START_PC=8'hFF with a legal load.
- Required response: HALT=1 after EXEC; PC_OUT=8'hFF; ERR=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants, types and helpers for the cpu_control sequencer.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;

  localparam logic [3:0] OP_ALU = 4'b0001;

  localparam logic [3:0] LOAD  = 4'h0;
  localparam logic [3:0] ADD   = 4'h1;
  localparam logic [3:0] SUB   = 4'h2;
  localparam logic [3:0] MUL   = 4'h3;
  localparam logic [3:0] DIV   = 4'h4;
  localparam logic [3:0] STORE = 4'hF;

  localparam logic [ADDR_W-1:0] START_PC_DEFAULT = 8'd100;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [3:0]        subop;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  // True when the instruction carries the ALU opcode and a defined sub-op.
  function automatic logic is_legal(input instr_t ins);
    return (ins.opcode == OP_ALU) &&
           (ins.subop inside {LOAD, ADD, SUB, MUL, DIV, STORE});
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub wrap, multiply keeps low half, unsigned divide.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] AR,
  input  logic [DATA_W-1:0] OPR,
  input  logic [3:0]        SUB_OP,
  output logic [DATA_W-1:0] RESULT,
  output logic              DIV0
);

  // Operation select; divide by zero saturates to all ones and flags DIV0.
  always_comb begin
    RESULT = '0;
    DIV0   = 1'b0;
    case (SUB_OP)
      ADD: RESULT = DATA_W'(AR + OPR);
      SUB: RESULT = DATA_W'(AR - OPR);
      MUL: RESULT = DATA_W'(AR * OPR);
      DIV: begin
        if (OPR == '0) begin
          RESULT = '1;
          DIV0   = 1'b1;
        end else begin
          RESULT = DATA_W'(AR / OPR);
        end
      end
      default: RESULT = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Three-cycle fetch/decode/execute sequencer driving instruction and data memory.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [7:0] START_PC = START_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [15:0] MAR,
  input  logic [15:0] OUT_MEMORY,
  output logic [7:0]  ADDRESS,
  input  logic [15:0] OUT_ADDRESS_MEMORY,
  output logic [15:0] IN_ADDRESS_MEMORY,
  output logic        MEM_WE,
  output logic [15:0] AR_OUT,
  output logic [15:0] RESULT_OUT,
  output logic [7:0]  PC_OUT,
  output logic        HALT,
  output logic        ERR
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  instr_t            ir_q;
  logic [DATA_W-1:0] opr_q, ar_q, result_q, din_q;
  logic              we_q, halt_q, err_q;

  logic              opr_ld, dec_err, exec_en;
  logic [DATA_W-1:0] alu_result;
  logic              alu_div0;

  cpu_alu u_alu (
    .AR     (ar_q),
    .OPR    (opr_q),
    .SUB_OP (ir_q.subop),
    .RESULT (alu_result),
    .DIV0   (alu_div0)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state and per-state control strobes.
  always_comb begin
    state_d = state_q;
    opr_ld  = 1'b0;
    dec_err = 1'b0;
    exec_en = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!is_legal(ir_q)) begin
          dec_err = 1'b1;
          state_d = HALTED;
        end else begin
          opr_ld  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        state_d = (pc_q == 8'hFF) ? HALTED : FETCH;
      end
      default: state_d = HALTED;
    endcase
  end

  // Datapath registers; the store strobe is registered so it is valid with stable address and data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q     <= START_PC;
      ir_q     <= '0;
      opr_q    <= '0;
      ar_q     <= '0;
      result_q <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (state_q == FETCH) ir_q <= instr_t'(OUT_MEMORY);
      if (opr_ld) opr_q <= OUT_ADDRESS_MEMORY;
      if (dec_err) err_q <= 1'b1;
      if (state_d == HALTED) halt_q <= 1'b1;
      if (exec_en) begin
        case (ir_q.subop)
          LOAD: ar_q <= opr_q;
          ADD, SUB, MUL, DIV: begin
            result_q <= alu_result;
            if (alu_div0) err_q <= 1'b1;
          end
          STORE: begin
            din_q <= result_q;
            we_q  <= 1'b1;
          end
          default: ;
        endcase
        if (pc_q != 8'hFF) pc_q <= ADDR_W'(pc_q + 8'd1);
      end
    end
  end

  assign MAR               = {8'h00, pc_q};
  assign ADDRESS           = ir_q.addr;
  assign IN_ADDRESS_MEMORY = din_q;
  assign MEM_WE            = we_q;
  assign AR_OUT            = ar_q;
  assign RESULT_OUT        = result_q;
  assign PC_OUT            = pc_q;
  assign HALT              = halt_q;
  assign ERR               = err_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: two instances (default start and START_PC=8'hFF).
module tb_cpu_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic [15:0] mem  [0:255];
  logic [15:0] mem2 [0:255];

  logic [15:0] mar, out_memory, out_address_memory, in_address_memory, ar_out, result_out;
  logic [7:0]  address, pc_out;
  logic        mem_we, halt, err;

  logic [15:0] mar2, out_memory2, out_address_memory2, in_address_memory2, ar_out2, result_out2;
  logic [7:0]  address2, pc_out2;
  logic        mem_we2, halt2, err2;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [7:0]  we_addr;
  logic [15:0] we_data;
  int snap;

  assign out_memory          = mem[mar[7:0]];
  assign out_address_memory  = mem[address];
  assign out_memory2         = mem2[mar2[7:0]];
  assign out_address_memory2 = mem2[address2];

  cpu_control u_dut (
    .CLK(clk), .RST_N(rst_n), .MAR(mar), .OUT_MEMORY(out_memory), .ADDRESS(address),
    .OUT_ADDRESS_MEMORY(out_address_memory), .IN_ADDRESS_MEMORY(in_address_memory),
    .MEM_WE(mem_we), .AR_OUT(ar_out), .RESULT_OUT(result_out), .PC_OUT(pc_out),
    .HALT(halt), .ERR(err)
  );

  cpu_control #(.START_PC(8'hFF)) u_dut_ff (
    .CLK(clk), .RST_N(rst2_n), .MAR(mar2), .OUT_MEMORY(out_memory2), .ADDRESS(address2),
    .OUT_ADDRESS_MEMORY(out_address_memory2), .IN_ADDRESS_MEMORY(in_address_memory2),
    .MEM_WE(mem_we2), .AR_OUT(ar_out2), .RESULT_OUT(result_out2), .PC_OUT(pc_out2),
    .HALT(halt2), .ERR(err2)
  );

  // Memory write port and store-pulse recorder.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[address] = in_address_memory;
      we_cnt  = we_cnt + 1;
      we_addr = address;
      we_data = in_address_memory;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic leave_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rst2_n = 1'b1;
    #2;
    rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    checks++; if (pc_out !== 8'd100) begin errors++; $display("FAIL reset_pc got %0d want 100", pc_out); end
    checks++; if (mar !== 16'd100) begin errors++; $display("FAIL reset_mar got %0d want 100", mar); end
    checks++; if (address !== 8'd0 || in_address_memory !== 16'd0) begin errors++; $display("FAIL reset_addr_data got %0d/%0d want 0/0", address, in_address_memory); end
    checks++; if (ar_out !== 16'd0 || result_out !== 16'd0) begin errors++; $display("FAIL reset_ar_result got %0d/%0d want 0/0", ar_out, result_out); end
    checks++; if (mem_we !== 1'b0 || halt !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got we=%b halt=%b err=%b want 0/0/0", mem_we, halt, err); end
    checks++; if (pc_out2 !== 8'hFF || mar2 !== 16'h00FF) begin errors++; $display("FAIL reset_pc_ff got %h/%h want ff/00ff", pc_out2, mar2); end
  endtask

  task automatic test_add_store();
    enter_reset();
    mem[1] = 16'd1; mem[2] = 16'd2;
    mem[100] = 16'h1001; mem[101] = 16'h1102; mem[102] = 16'h1F07;
    leave_reset();
    snap = we_cnt;
    for (int k = 1; k <= 9; k++) begin
      cycles(1);
      checks++;
      if (mar !== 16'(100 + k / 3)) begin errors++; $display("FAIL mar_timing edge %0d got %0d want %0d", k, mar, 100 + k / 3); end
    end
    cycles(1);
    checks++; if (result_out !== 16'd3) begin errors++; $display("FAIL add_result got %0d want 3", result_out); end
    checks++; if (we_cnt - snap !== 1) begin errors++; $display("FAIL store_pulses got %0d want 1", we_cnt - snap); end
    checks++; if (we_addr !== 8'd7 || we_data !== 16'd3) begin errors++; $display("FAIL store_addr_data got %0d/%0d want 7/3", we_addr, we_data); end
    checks++; if (mem[7] !== 16'd3) begin errors++; $display("FAIL store_mem7 got %0d want 3", mem[7]); end
  endtask

  task automatic test_sub_mul();
    enter_reset();
    mem[3] = 16'd128; mem[4] = 16'd64; mem[5] = 16'd12; mem[6] = 16'd12;
    mem[100] = 16'h1003; mem[101] = 16'h1204; mem[102] = 16'h1006; mem[103] = 16'h1305;
    leave_reset();
    cycles(6);
    checks++; if (result_out !== 16'd64) begin errors++; $display("FAIL sub_result got %0d want 64", result_out); end
    cycles(6);
    checks++; if (result_out !== 16'd144 || ar_out !== 16'd12) begin errors++; $display("FAIL mul_result got %0d ar %0d want 144 ar 12", result_out, ar_out); end
  endtask

  task automatic test_wrap();
    enter_reset();
    mem[11] = 16'hFFFF; mem[12] = 16'd2; mem[13] = 16'h0100;
    mem[100] = 16'h100B; mem[101] = 16'h110C; mem[102] = 16'h100D;
    mem[103] = 16'h130D; mem[104] = 16'h120C;
    leave_reset();
    cycles(6);
    checks++; if (result_out !== 16'h0001) begin errors++; $display("FAIL add_wrap got %h want 0001", result_out); end
    cycles(6);
    checks++; if (result_out !== 16'h0000) begin errors++; $display("FAIL mul_low got %h want 0000", result_out); end
    cycles(3);
    checks++; if (result_out !== 16'h00FE) begin errors++; $display("FAIL sub_small got %h want 00fe", result_out); end
  endtask

  task automatic test_div();
    enter_reset();
    mem[8] = 16'd3072; mem[9] = 16'd2; mem[10] = 16'd0;
    mem[100] = 16'h1008; mem[101] = 16'h1409; mem[102] = 16'h140A;
    leave_reset();
    cycles(6);
    checks++; if (result_out !== 16'd1536 || err !== 1'b0) begin errors++; $display("FAIL div_result got %0d err %b want 1536 err 0", result_out, err); end
    cycles(3);
    checks++; if (result_out !== 16'hFFFF || err !== 1'b1) begin errors++; $display("FAIL div0_result got %h err %b want ffff err 1", result_out, err); end
    checks++; if (pc_out !== 8'd103 || halt !== 1'b0) begin errors++; $display("FAIL div0_continue got pc %0d halt %b want 103 0", pc_out, halt); end
  endtask

  task automatic test_halt();
    enter_reset();
    mem[1] = 16'd1; mem[2] = 16'd2;
    mem[100] = 16'h1001; mem[101] = 16'h1102; mem[102] = 16'h1F07; mem[103] = 16'h0000;
    leave_reset();
    cycles(10);
    checks++; if (halt !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL pre_halt got halt %b err %b want 0 0", halt, err); end
    cycles(1);
    checks++; if (halt !== 1'b1 || err !== 1'b1 || pc_out !== 8'd103) begin errors++; $display("FAIL halt_illegal got halt %b err %b pc %0d want 1 1 103", halt, err, pc_out); end
    snap = we_cnt;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      checks++;
      if (mem_we !== 1'b0 || pc_out !== 8'd103 || mar !== 16'd103) begin
        errors++; $display("FAIL halt_frozen cycle %0d got we %b pc %0d mar %0d want 0 103 103", k, mem_we, pc_out, mar);
      end
    end
    checks++; if (we_cnt !== snap) begin errors++; $display("FAIL halt_no_store got %0d pulses want 0", we_cnt - snap); end
  endtask

  task automatic test_reset_mid_store();
    enter_reset();
    mem[1] = 16'd1; mem[2] = 16'd2; mem[7] = 16'hAAAA;
    mem[100] = 16'h1001; mem[101] = 16'h1102; mem[102] = 16'h1F07;
    leave_reset();
    snap = we_cnt;
    cycles(8);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || pc_out !== 8'd100 || mar !== 16'd100) begin errors++; $display("FAIL midreset_now got we %b pc %0d mar %0d want 0 100 100", mem_we, pc_out, mar); end
    cycles(3);
    checks++; if (mem[7] !== 16'hAAAA || we_cnt !== snap) begin errors++; $display("FAIL midreset_nowrite got %h pulses %0d want aaaa 0", mem[7], we_cnt - snap); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (pc_out !== 8'd100 || mar !== 16'd100) begin errors++; $display("FAIL midreset_release got pc %0d mar %0d want 100 100", pc_out, mar); end
    cycles(1);
    checks++; if (address !== 8'd1 || pc_out !== 8'd100) begin errors++; $display("FAIL first_fetch got addr %0d pc %0d want 1 100", address, pc_out); end
  endtask

  task automatic test_end_of_memory();
    for (int i = 0; i < 256; i++) mem2[i] = 16'h0000;
    mem2[255] = 16'h1001; mem2[1] = 16'h1234;
    @(negedge clk);
    rst2_n = 1'b1;
    cycles(2);
    checks++; if (halt2 !== 1'b0) begin errors++; $display("FAIL eom_early_halt got %b want 0", halt2); end
    cycles(1);
    checks++; if (halt2 !== 1'b1 || pc_out2 !== 8'hFF || err2 !== 1'b0) begin errors++; $display("FAIL eom_halt got halt %b pc %h err %b want 1 ff 0", halt2, pc_out2, err2); end
    checks++; if (ar_out2 !== 16'h1234) begin errors++; $display("FAIL eom_load got %h want 1234", ar_out2); end
    cycles(5);
    checks++; if (pc_out2 !== 8'hFF || mar2 !== 16'h00FF || mem_we2 !== 1'b0) begin errors++; $display("FAIL eom_frozen got pc %h mar %h we %b want ff 00ff 0", pc_out2, mar2, mem_we2); end
  endtask

  initial begin
    test_reset();
    test_add_store();
    test_sub_mul();
    test_wrap();
    test_div();
    test_halt();
    test_reset_mid_store();
    test_end_of_memory();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
